// File: rtl/conv2_flatten_buffer_if.sv
// Layer-2 output stream into the flatten buffer, plus the flattened replay stream
// towards the fully-connected stage.
interface conv2_flatten_buffer_if #(
  parameter int BW = 16
);
  logic signed [BW-1:0] i_data;
  logic                 i_valid;
  logic                 i_ch_end;
  logic                 i_rd_ce;
  logic signed [BW-1:0] o_data;
  logic                 o_valid;
  logic                 o_ch_end;
  logic                 o_last;
  logic                 o_full;
  logic                 o_done;
  logic                 o_err;

  modport master (
    output i_data, i_valid, i_ch_end, i_rd_ce,
    input  o_data, o_valid, o_ch_end, o_last, o_full, o_done, o_err
  );

  modport slave (
    input  i_data, i_valid, i_ch_end, i_rd_ce,
    output o_data, o_valid, o_ch_end, o_last, o_full, o_done, o_err
  );
endinterface

// File: rtl/conv2_flatten_buffer.sv
// Buffers one image of pooled layer-2 feature maps (channel-major) and replays it
// as a single flattened vector under the consumer read enable.
module conv2_flatten_buffer #(
  parameter int BW      = 16,
  parameter int O_SIZE  = 4,
  parameter int CO      = 12,
  parameter int DEPTH   = CO * O_SIZE * O_SIZE,
  parameter int ADDR_BW = 8
) (
  input  logic                   clk,
  input  logic                   global_rst_n,
  input  logic                   rst_processEnd,
  conv2_flatten_buffer_if.slave  bus
);

  localparam int                 CH_WORDS   = O_SIZE * O_SIZE;
  localparam logic [ADDR_BW-1:0] LAST_ADDR  = ADDR_BW'(DEPTH - 1);
  localparam logic [ADDR_BW-1:0] CH_LAST    = ADDR_BW'(CH_WORDS - 1);
  localparam logic [ADDR_BW-1:0] CH_WORDS_A = ADDR_BW'(CH_WORDS);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t               state_q;
  logic [ADDR_BW-1:0]   wr_addr_q;
  logic [ADDR_BW-1:0]   rd_addr_q;
  logic [ADDR_BW-1:0]   ch_cnt_q;
  logic [ADDR_BW-1:0]   rd_ch_q;
  logic signed [BW-1:0] data_q;
  logic                 valid_q;
  logic                 ch_end_q;
  logic                 last_q;
  logic                 full_q;
  logic                 done_q;
  logic                 err_q;

  logic signed [BW-1:0] mem [DEPTH];

  logic                 accepting;
  logic                 wr_en;
  logic                 rd_en;
  logic [ADDR_BW-1:0]   ch_cnt_d;
  logic                 ch_end_bad;
  logic                 overflow;

  assign accepting  = (state_q == IDLE) || (state_q == FILL);
  assign wr_en      = !rst_processEnd && accepting && bus.i_valid;
  assign rd_en      = !rst_processEnd && (state_q == DRAIN) && bus.i_rd_ce;
  // Channel length check must count a write landing in the same cycle as i_ch_end.
  assign ch_cnt_d   = ch_cnt_q + ADDR_BW'(wr_en);
  assign ch_end_bad = accepting && bus.i_ch_end && (ch_cnt_d != CH_WORDS_A);
  assign overflow   = !accepting && bus.i_valid;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr_q] <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      ch_cnt_q  <= '0;
      rd_ch_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ch_end_q  <= 1'b0;
      last_q    <= 1'b0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (rst_processEnd) begin
      // Rearm for the next image; RAM contents and o_data are left as they are.
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      ch_cnt_q  <= '0;
      rd_ch_q   <= '0;
      valid_q   <= 1'b0;
      ch_end_q  <= 1'b0;
      last_q    <= 1'b0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q  <= rd_en;
      ch_end_q <= rd_en && (rd_ch_q == CH_LAST);
      last_q   <= rd_en && (rd_addr_q == LAST_ADDR);
      if (rd_en) begin
        data_q    <= mem[rd_addr_q];
        rd_addr_q <= rd_addr_q + 1'b1;
        rd_ch_q   <= (rd_ch_q == CH_LAST) ? '0 : rd_ch_q + 1'b1;
      end

      if (ch_end_bad || overflow) begin
        err_q <= 1'b1;
      end

      if (accepting && bus.i_ch_end) begin
        ch_cnt_q <= '0;
      end else if (wr_en) begin
        ch_cnt_q <= ch_cnt_d;
      end

      if (wr_en) begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end

      case (state_q)
        IDLE, FILL: begin
          if (wr_en) begin
            if (wr_addr_q == LAST_ADDR) begin
              state_q <= DRAIN;
              full_q  <= 1'b1;
            end else begin
              state_q <= FILL;
            end
          end
        end
        DRAIN: begin
          if (rd_en && (rd_addr_q == LAST_ADDR)) begin
            state_q <= DONE;
            full_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_data   = data_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_ch_end = ch_end_q;
  assign bus.o_last   = last_q;
  assign bus.o_full   = full_q;
  assign bus.o_done   = done_q;
  assign bus.o_err    = err_q;

endmodule

// File: doc/conv2_flatten_buffer.md
# conv2_flatten_buffer

Stores the max-pooled, truncated output feature maps of convolution layer 2 (CO channels of O_SIZE×O_SIZE words, channel-major raster order) and replays them as one flattened vector to the fully-connected stage. It is the reading side of the layer-2 output stream: it consumes the result/enable/channel-end signals that layer 2 produces and drains them under a consumer clock-enable. One image is buffered per process cycle; rst_processEnd rearms it for the next image.

## Interface
- BW, 16, data word width (matches layer-2 O_BW)
- O_SIZE, 4, pooled map side length
- CO, 12, number of channels
- DEPTH, CO*O_SIZE*O_SIZE = 192, total words buffered
- ADDR_BW, 8, address/counter width; must satisfy 2^ADDR_BW ≥ DEPTH

- clk  in  1  clock, all state on rising edge
- global_rst_n  in  1  reset, asynchronous, active-low
- rst_processEnd  in  1  synchronous clear, highest priority after global_rst_n
- i_data  in  BW (signed)  pooled word from layer 2
- i_valid  in  1  i_data valid this cycle (layer-2 enable)
- i_ch_end  in  1  one-cycle pulse, current channel complete
- i_rd_ce  in  1  consumer read enable, one word requested per asserted cycle
- o_data  out  BW (signed)  flattened word, registered
- o_valid  out  1  o_data valid
- o_ch_end  out  1  with o_valid on the last word of each channel
- o_last  out  1  with o_valid on word DEPTH-1
- o_full  out  1  buffer holds a complete image (state DRAIN)
- o_done  out  1  level, all DEPTH words delivered
- o_err  out  1  sticky protocol error flag

## Operation
- Storage: single-port RAM, DEPTH×BW, no reset on contents; 1-cycle synchronous read.
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE: first i_valid writes address 0 and moves to FILL (write happens in that same cycle).
- FILL: each i_valid writes i_data at wr_addr, wr_addr++; ch_cnt (words in current channel) increments. Write of address DEPTH-1 -> DRAIN next cycle. i_rd_ce ignored.
- i_ch_end check (any state up to DRAIN entry): ch_cnt including any same-cycle write must equal O_SIZE*O_SIZE, else o_err<=1. ch_cnt cleared on i_ch_end.
- DRAIN: each cycle with i_rd_ce=1 issues a read of rd_addr, rd_addr++. Issuing the read of DEPTH-1 -> DONE next cycle.
- DONE: o_done=1; holds until rst_processEnd or global_rst_n -> IDLE.
- i_valid in DRAIN or DONE: word dropped, RAM unchanged, o_err<=1.
- o_ch_end when delivered index mod (O_SIZE*O_SIZE) = O_SIZE*O_SIZE-1; o_last when index = DEPTH-1 (coincides with o_ch_end).
- o_err is sticky; cleared only by rst_processEnd or global_rst_n.
- rst_processEnd: state->IDLE, wr_addr/rd_addr/ch_cnt->0, o_valid/o_ch_end/o_last/o_done/o_err->0 next edge; RAM contents kept. Overrides i_valid/i_rd_ce in the same cycle (no write, no read).

## Timing
- Reset values: o_data=0, o_valid=0, o_ch_end=0, o_last=0, o_full=0, o_done=0, o_err=0, state IDLE.
- Write: zero-latency capture on the i_valid edge; full rate, one word per cycle.
- Final write at edge t -> o_full=1 from t+1; first effective i_rd_ce sampled at t+1.
- Read latency 1: i_rd_ce sampled at edge n -> o_valid, o_data, o_ch_end, o_last registered at edge n+1, high for one cycle.
- o_data holds its last value while o_valid=0.
- Read of DEPTH-1 issued at edge n -> o_last at n+1, o_full=0 and o_done=1 from n+1.
- Back-to-back i_rd_ce gives DEPTH words in DEPTH consecutive cycles; gaps in i_rd_ce produce matching gaps in o_valid, order preserved.

## Test plan
- Nominal: write words 0..191 continuously, i_ch_end with writes 15,31,…,191; i_rd_ce=1 from o_full -> o_data 0..191 on consecutive cycles, o_ch_end on 15,31,…,191, o_last and o_done on 191, o_err=0.
- Stalled drain: same fill, i_rd_ce=1,0,1,0… -> o_valid alternates one cycle later, values 0..191 in order, o_done after 383 drain cycles.
- Early channel end: i_ch_end after 10 writes -> o_err=1 next cycle and stays 1 through drain; rst_processEnd -> o_err=0.
- Overflow: after full, drive i_valid with 0xFFFF for 5 cycles during DRAIN -> o_err=1, drained data still 0..191.
- Mid-drain clear: rst_processEnd after 50 words delivered -> o_valid=0 next cycle, o_full=0; refill with 1000+i -> drain delivers 1000..1191.
- Async reset during FILL after 100 writes -> all outputs at reset values immediately; fresh 192-word fill and drain completes normally.
